// File: rtl/prog_onehot_fsm.sv
// Programmable one-hot state machine: a writable table maps {state, input symbol}
// to {next state, output}; illegal states or targets fall back to state bit0.
module prog_onehot_fsm #(
    parameter  int N_STATES = 8,
    parameter  int IN_W     = 2,
    parameter  int OUT_W    = 2,
    localparam int SW       = $clog2(N_STATES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_W-1:0]      in,
    input  logic                 cfg_we,
    input  logic [SW+IN_W-1:0]   cfg_addr,
    input  logic [SW+OUT_W-1:0]  cfg_wdata,
    output logic [OUT_W-1:0]     out,
    output logic [N_STATES-1:0]  state,
    output logic                 step_vld,
    output logic                 cfg_err,
    output logic                 state_err
);

    localparam int AW    = SW + IN_W;
    localparam int EW    = SW + OUT_W;
    localparam int NSYM  = 1 << IN_W;
    localparam int DEPTH = N_STATES * NSYM;

    typedef logic [EW-1:0] entry_t;

    entry_t               tbl_q [DEPTH];
    entry_t               tbl_d [DEPTH];
    logic [N_STATES-1:0]  state_q, state_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 step_vld_q, step_vld_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 state_err_q, state_err_d;

    logic [SW-1:0]        cur_idx;
    entry_t               rd_entry;
    logic [SW-1:0]        rd_next;
    logic [OUT_W-1:0]     rd_outv;
    logic [SW-1:0]        wr_idx;
    logic                 wr_ok;
    logic                 next_ok;

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < N_STATES; i++) begin
            if (state_q[i]) cur_idx = cur_idx | SW'(i);
        end
    end

    // The step reads tbl_q, so a same-cycle write only affects later steps.
    assign rd_entry = tbl_q[{cur_idx, in}];
    assign rd_next  = rd_entry[EW-1:OUT_W];
    assign rd_outv  = rd_entry[OUT_W-1:0];
    assign next_ok  = 32'(rd_next) < 32'(N_STATES);
    assign wr_idx   = cfg_addr[AW-1:IN_W];
    assign wr_ok    = 32'(wr_idx) < 32'(N_STATES);

    always_comb begin
        tbl_d       = tbl_q;
        state_d     = state_q;
        out_d       = out_q;
        step_vld_d  = 1'b0;
        cfg_err_d   = 1'b0;
        state_err_d = state_err_q;

        if (cfg_we) begin
            if (wr_ok) tbl_d[cfg_addr] = cfg_wdata;
            else       cfg_err_d       = 1'b1;
        end

        if (en) begin
            step_vld_d = 1'b1;
            if (!$onehot(state_q) || !next_ok) begin
                state_d     = N_STATES'(1);
                out_d       = '0;
                state_err_d = 1'b1;
            end else begin
                state_d          = '0;
                state_d[rd_next] = 1'b1;
                out_d            = rd_outv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= N_STATES'(1);
            out_q       <= '0;
            step_vld_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            state_err_q <= 1'b0;
            // Every entry becomes a self-loop with zero output.
            for (int s = 0; s < N_STATES; s++) begin
                for (int i = 0; i < NSYM; i++) begin
                    tbl_q[AW'(s * NSYM + i)] <= {SW'(s), OUT_W'(0)};
                end
            end
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            step_vld_q  <= step_vld_d;
            cfg_err_q   <= cfg_err_d;
            state_err_q <= state_err_d;
            tbl_q       <= tbl_d;
        end
    end

    assign state     = state_q;
    assign out       = out_q;
    assign step_vld  = step_vld_q;
    assign cfg_err   = cfg_err_q;
    assign state_err = state_err_q;

endmodule

// File: tb/tb_prog_onehot_fsm.sv
// Scoreboard bench: dut_a (8 states) and dut_b (6 states, for out-of-range cases);
// expected {state,out} pushed at stimulus time, popped by monitors on step_vld.
module tb_prog_onehot_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, we_a;
    logic [1:0] in_a, out_a;
    logic [4:0] addr_a, wd_a;
    logic [7:0] st_a;
    logic       vld_a, cerr_a, serr_a;

    logic       rst_b, en_b, we_b;
    logic [1:0] in_b, out_b;
    logic [4:0] addr_b, wd_b;
    logic [5:0] st_b;
    logic       vld_b, cerr_b, serr_b;

    prog_onehot_fsm #(.N_STATES(8), .IN_W(2), .OUT_W(2)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .in(in_a), .cfg_we(we_a),
        .cfg_addr(addr_a), .cfg_wdata(wd_a), .out(out_a), .state(st_a),
        .step_vld(vld_a), .cfg_err(cerr_a), .state_err(serr_a)
    );

    prog_onehot_fsm #(.N_STATES(6), .IN_W(2), .OUT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .in(in_b), .cfg_we(we_b),
        .cfg_addr(addr_b), .cfg_wdata(wd_b), .out(out_b), .state(st_b),
        .step_vld(vld_b), .cfg_err(cerr_b), .state_err(serr_b)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q_a[$];
    logic [7:0] q_b[$];
    logic [9:0] exp_a;
    logic [7:0] exp_b;

    logic [4:0] m_tbl [32];
    int         m_st;
    logic [1:0] m_out;

    always @(negedge clk) begin
        if (vld_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL step_a: unexpected step, got state=%h out=%h, required no step", st_a, out_a);
            end else begin
                exp_a = q_a.pop_front();
                if ({st_a, out_a} !== exp_a) begin
                    errors++;
                    $display("FAIL step_a: got state=%h out=%h, required state=%h out=%h",
                             st_a, out_a, exp_a[9:2], exp_a[1:0]);
                end
            end
        end
        if (vld_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL step_b: unexpected step, got state=%h out=%h, required no step", st_b, out_b);
            end else begin
                exp_b = q_b.pop_front();
                if ({st_b, out_b} !== exp_b) begin
                    errors++;
                    $display("FAIL step_b: got state=%h out=%h, required state=%h out=%h",
                             st_b, out_b, exp_b[7:2], exp_b[1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wr_a(input logic [4:0] addr, input logic [4:0] wd);
        we_a = 1'b1; addr_a = addr; wd_a = wd;
        tick();
        we_a = 1'b0;
        chk("cfg_err_a_legal", 32'(cerr_a), 0);
    endtask

    task automatic wr_b(input logic [4:0] addr, input logic [4:0] wd);
        we_b = 1'b1; addr_b = addr; wd_b = wd;
        tick();
        we_b = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 4; i++)
                m_tbl[s*4+i] = {3'(s), 2'b00};
        m_st  = 0;
        m_out = 2'b00;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; we_a = 1'b0; in_a = '0; addr_a = '0; wd_a = '0;
        rst_b = 1'b1; en_b = 1'b0; we_b = 1'b0; in_b = '0; addr_b = '0; wd_b = '0;
        tick(); tick();
        chk("rst_state_a", 32'(st_a), 32'h01);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_vld_a", 32'(vld_a), 0);
        chk("rst_cerr_a", 32'(cerr_a), 0);
        chk("rst_serr_a", 32'(serr_a), 0);
        chk("rst_state_b", 32'(st_b), 32'h01);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset table self-loops at s0 with zero output.
        en_a = 1'b1; in_a = 2'd3;
        repeat (4) begin
            q_a.push_back({8'h01, 2'b00});
            tick();
            chk("selfloop_vld", 32'(vld_a), 1);
        end
        en_a = 1'b0;
        tick();
        chk("hold_vld", 32'(vld_a), 0);
        chk("hold_state", 32'(st_a), 32'h01);

        // Program s0->s1->s2->s0 on symbol 1.
        wr_a({3'd0, 2'd1}, {3'd1, 2'b01});
        wr_a({3'd1, 2'd1}, {3'd2, 2'b11});
        wr_a({3'd2, 2'd1}, {3'd0, 2'b00});
        en_a = 1'b1; in_a = 2'd1;
        q_a.push_back({8'h02, 2'b01}); tick();
        q_a.push_back({8'h04, 2'b11}); tick();
        q_a.push_back({8'h01, 2'b00}); tick();

        // Step and rewrite (s0,1) together: the step sees the old entry.
        we_a = 1'b1; addr_a = {3'd0, 2'd1}; wd_a = {3'd5, 2'b10};
        q_a.push_back({8'h02, 2'b01}); tick();
        we_a = 1'b0;
        q_a.push_back({8'h04, 2'b11}); tick();
        q_a.push_back({8'h01, 2'b00}); tick();
        q_a.push_back({8'h20, 2'b10}); tick();
        en_a = 1'b0;
        tick();
        chk("rbw_state", 32'(st_a), 32'h20);
        chk("rbw_out", 32'(out_a), 32'h2);

        // Out-of-range write address on the 6-state instance.
        wr_b({3'd6, 2'd0}, {3'd1, 2'b11});
        chk("cfg_err_pulse", 32'(cerr_b), 1);
        tick();
        chk("cfg_err_clear", 32'(cerr_b), 0);
        en_b = 1'b1; in_b = 2'd0;
        q_b.push_back({6'h01, 2'b00}); tick();
        en_b = 1'b0;

        // Next field beyond N_STATES falls back to bit0 and sets state_err.
        wr_b({3'd0, 2'd1}, {3'd2, 2'b01});
        wr_b({3'd2, 2'd0}, {3'd7, 2'b11});
        wr_b({3'd0, 2'd0}, {3'd7, 2'b11});
        chk("serr_before", 32'(serr_b), 0);
        en_b = 1'b1;
        in_b = 2'd1; q_b.push_back({6'h04, 2'b01}); tick();
        in_b = 2'd0; q_b.push_back({6'h01, 2'b00}); tick();
        chk("serr_set", 32'(serr_b), 1);
        in_b = 2'd0; q_b.push_back({6'h01, 2'b00}); tick();
        in_b = 2'd1; q_b.push_back({6'h04, 2'b01}); tick();
        en_b = 1'b0;
        tick(); tick();
        chk("serr_sticky", 32'(serr_b), 1);

        // Reset beats a simultaneous step and write; the write is lost.
        rst_b = 1'b1; en_b = 1'b1; in_b = 2'd1;
        we_b = 1'b1; addr_b = {3'd0, 2'd1}; wd_b = {3'd3, 2'b10};
        tick();
        rst_b = 1'b0; we_b = 1'b0;
        chk("rstprio_state", 32'(st_b), 32'h01);
        chk("rstprio_out", 32'(out_b), 0);
        chk("rstprio_vld", 32'(vld_b), 0);
        chk("rstprio_serr", 32'(serr_b), 0);
        q_b.push_back({6'h01, 2'b00}); tick();
        en_b = 1'b0;

        // Full random table, random symbols, reset at cycle 10.
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                m_tbl[s*4+i] = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                wr_a({3'(s), 2'(i)}, m_tbl[s*4+i]);
            end
        end
        for (int c = 0; c < 20; c++) begin
            in_a = 2'($urandom_range(0, 3));
            en_a = 1'b1;
            if (c == 10) begin
                rst_a = 1'b1;
                tick();
                rst_a = 1'b0;
                chk("midrst_state", 32'(st_a), 32'h01);
                chk("midrst_out", 32'(out_a), 0);
                chk("midrst_vld", 32'(vld_a), 0);
                model_reset();
            end else begin
                m_out = m_tbl[m_st*4 + int'(in_a)][1:0];
                m_st  = int'(m_tbl[m_st*4 + int'(in_a)][4:2]);
                q_a.push_back({8'(1 << m_st), m_out});
                tick();
            end
        end
        en_a = 1'b0;
        tick(); tick();

        chk("q_a_drained", 32'(q_a.size()), 0);
        chk("q_b_drained", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
